// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_access_ctrl : MEM-stage load/store initiator for the 256x64 data memory
// Optional macro DMEM_BOUNDS_CHECK_EN rejects out-of-range loads/stores.
// Revision 1.0
// ============================================================================
module dmem_access_ctrl #(
    parameter int DATA_W     = 64,
    parameter int ADDR_BITS  = 8,
    parameter int RD_LATENCY = 1,
    parameter int RD_W       = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              req_ready,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              addr_err
);

    localparam int               CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

    if (RD_LATENCY < 1 || ADDR_BITS < 1 || ADDR_BITS >= DATA_W) begin : g_bad_params
        $error("dmem_access_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_WR = 2'd1,
        BUSY_RD = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [RD_W-1:0]   op_rd, op_rd_nxt;
    logic [DATA_W-1:0] mem_address_nxt, mem_write_data_nxt, wb_data_nxt;
    logic              mem_write_nxt, mem_read_nxt, wb_valid_nxt, wb_we_nxt;
    logic [RD_W-1:0]   wb_rd_nxt;
    logic              accept;

    // Gated by rst_n so every output reads 0 while reset is held
    assign req_ready = rst_n & (state == IDLE);
    assign accept    = req_valid & req_ready;

`ifdef DMEM_BOUNDS_CHECK_EN
    logic addr_err_nxt;
    logic oor_reject;
    assign oor_reject = (req_read | req_write) & (|req_addr[DATA_W-1:ADDR_BITS]);
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        state_nxt          = state;
        cnt_nxt            = cnt;
        op_rd_nxt          = op_rd;
        mem_address_nxt    = mem_address;
        mem_write_data_nxt = mem_write_data;
        mem_write_nxt      = 1'b0;
        mem_read_nxt       = 1'b0;
        wb_valid_nxt       = 1'b0;
        wb_we_nxt          = wb_we;
        wb_data_nxt        = wb_data;
        wb_rd_nxt          = wb_rd;
`ifdef DMEM_BOUNDS_CHECK_EN
        addr_err_nxt       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DMEM_BOUNDS_CHECK_EN
                    if (oor_reject) begin
                        wb_valid_nxt = 1'b1;
                        wb_we_nxt    = 1'b0;
                        wb_data_nxt  = '0;
                        wb_rd_nxt    = req_rd;
                        addr_err_nxt = 1'b1;
                    end else
`endif
                    if (req_write) begin
                        mem_address_nxt    = req_addr;
                        mem_write_data_nxt = req_wdata;
                        mem_write_nxt      = 1'b1;
                        op_rd_nxt          = req_rd;
                        state_nxt          = BUSY_WR;
                    end else if (req_read) begin
                        mem_address_nxt = req_addr;
                        mem_read_nxt    = 1'b1;
                        cnt_nxt         = CNT_INIT;
                        op_rd_nxt       = req_rd;
                        state_nxt       = BUSY_RD;
                    end else begin
                        wb_valid_nxt = 1'b1;
                        wb_we_nxt    = 1'b1;
                        wb_data_nxt  = req_addr;
                        wb_rd_nxt    = req_rd;
                    end
                end
            end
            BUSY_WR: begin
                wb_valid_nxt = 1'b1;
                wb_we_nxt    = 1'b0;
                wb_data_nxt  = '0;
                wb_rd_nxt    = op_rd;
                state_nxt    = IDLE;
            end
            BUSY_RD: begin
                if (cnt != '0) begin
                    cnt_nxt      = cnt - CNT_W'(1);
                    mem_read_nxt = 1'b1;
                end else begin
                    wb_valid_nxt = 1'b1;
                    wb_we_nxt    = 1'b1;
                    wb_data_nxt  = mem_readdata;
                    wb_rd_nxt    = op_rd;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            op_rd          <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            wb_valid       <= 1'b0;
            wb_we          <= 1'b0;
            wb_data        <= '0;
            wb_rd          <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            op_rd          <= op_rd_nxt;
            mem_address    <= mem_address_nxt;
            mem_write_data <= mem_write_data_nxt;
            mem_write      <= mem_write_nxt;
            mem_read       <= mem_read_nxt;
            wb_valid       <= wb_valid_nxt;
            wb_we          <= wb_we_nxt;
            wb_data        <= wb_data_nxt;
            wb_rd          <= wb_rd_nxt;
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_err <= 1'b0;
        else        addr_err <= addr_err_nxt;
    end
`endif

endmodule
`default_nettype wire
